// File: rtl/decode_pkg.sv
// Shared encodings and the execute-stage control bundle for the MIPS-subset decode stage.
package decode_pkg;

  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_ADDIU  = 6'b001001;
  localparam logic [5:0] OP_ORI    = 6'b001101;
  localparam logic [5:0] OP_LUI    = 6'b001111;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_SW     = 6'b101011;

  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLTU = 6'b101011;

  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_UNDF = 3'b011;
  localparam logic [2:0] ALU_LUI  = 3'b100;
  localparam logic [2:0] ALU_LTZ  = 3'b101;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_SLTU = 3'b111;

  typedef struct packed {
    logic       regwrite;
    logic       memwrite;
    logic       memtoreg;
    logic       alusrcbimm;
    logic       dojump;
    logic       beq;
    logic       bltz;
    logic       illegal;
    logic [4:0] destreg;
    logic [2:0] alucontrol;
  } ctrl_t;

  // All-zero bundle used for reset and bubbles.
  function automatic ctrl_t ctrl_zero();
    ctrl_t c;
    c.regwrite   = 1'b0;
    c.memwrite   = 1'b0;
    c.memtoreg   = 1'b0;
    c.alusrcbimm = 1'b0;
    c.dojump     = 1'b0;
    c.beq        = 1'b0;
    c.bltz       = 1'b0;
    c.illegal    = 1'b0;
    c.destreg    = 5'd0;
    c.alucontrol = 3'b000;
    return c;
  endfunction

  // True when the instruction reads rt as a register source.
  function automatic logic reads_rt(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/decode_logic.sv
// Purely combinational instruction decoder producing the execute control bundle.
module decode_logic
  import decode_pkg::*;
(
  input  logic [5:0] op,
  input  logic [4:0] rt,
  input  logic [4:0] rd,
  input  logic [5:0] funct,
  output ctrl_t      ctrl
);

  ctrl_t ctrl_s;

  // Opcode/funct decode; anything unrecognised falls to the illegal bundle.
  always_comb begin
    ctrl_s = ctrl_zero();
    ctrl_s.alucontrol = ALU_UNDF;
    case (op)
      OP_RTYPE: begin
        ctrl_s.regwrite = 1'b1;
        ctrl_s.destreg  = rd;
        case (funct)
          FN_ADDU: ctrl_s.alucontrol = ALU_ADD;
          FN_SUBU: ctrl_s.alucontrol = ALU_SUB;
          FN_AND:  ctrl_s.alucontrol = ALU_AND;
          FN_OR:   ctrl_s.alucontrol = ALU_OR;
          FN_SLTU: ctrl_s.alucontrol = ALU_SLTU;
          default: begin
            ctrl_s = ctrl_zero();
            ctrl_s.alucontrol = ALU_UNDF;
            ctrl_s.illegal    = 1'b1;
          end
        endcase
      end
      OP_LW: begin
        ctrl_s.alucontrol = ALU_ADD;
        ctrl_s.alusrcbimm = 1'b1;
        ctrl_s.memtoreg   = 1'b1;
        ctrl_s.regwrite   = 1'b1;
        ctrl_s.destreg    = rt;
      end
      OP_SW: begin
        ctrl_s.alucontrol = ALU_ADD;
        ctrl_s.alusrcbimm = 1'b1;
        ctrl_s.memwrite   = 1'b1;
      end
      OP_BEQ: begin
        ctrl_s.alucontrol = ALU_SUB;
        ctrl_s.beq        = 1'b1;
      end
      OP_REGIMM: begin
        if (rt == 5'd0) begin
          ctrl_s.alucontrol = ALU_LTZ;
          ctrl_s.bltz       = 1'b1;
        end else begin
          ctrl_s.illegal    = 1'b1;
        end
      end
      OP_ADDIU: begin
        ctrl_s.alucontrol = ALU_ADD;
        ctrl_s.alusrcbimm = 1'b1;
        ctrl_s.regwrite   = 1'b1;
        ctrl_s.destreg    = rt;
      end
      OP_ORI: begin
        ctrl_s.alucontrol = ALU_OR;
        ctrl_s.alusrcbimm = 1'b1;
        ctrl_s.regwrite   = 1'b1;
        ctrl_s.destreg    = rt;
      end
      OP_LUI: begin
        ctrl_s.alucontrol = ALU_LUI;
        ctrl_s.alusrcbimm = 1'b1;
        ctrl_s.regwrite   = 1'b1;
        ctrl_s.destreg    = rt;
      end
      OP_J: begin
        ctrl_s.dojump = 1'b1;
      end
      default: begin
        ctrl_s.illegal = 1'b1;
      end
    endcase
  end

  assign ctrl = ctrl_s;

endmodule

// File: rtl/decode_stage.sv
// Decode pipeline stage: valid/ready handshake, load-use stall, flush and the
// registered execute-stage control bundle.
module decode_stage
  import decode_pkg::*;
#(
  parameter int PC_W      = 32,
  parameter int HAZARD_EN = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  output logic            in_ready,
  input  logic            flush,
  input  logic            ex_ready,
  output logic            ex_valid,
  output logic [PC_W-1:0] ex_pc,
  output logic [31:0]     ex_instr,
  output logic            ex_regwrite,
  output logic            ex_memwrite,
  output logic            ex_memtoreg,
  output logic            ex_alusrcbimm,
  output logic            ex_dojump,
  output logic            ex_beq,
  output logic            ex_bltz,
  output logic            ex_illegal,
  output logic [4:0]      ex_destreg,
  output logic [2:0]      ex_alucontrol
);

  ctrl_t           dec_s;
  ctrl_t           ctrl_r;
  logic            valid_r;
  logic [PC_W-1:0] pc_r;
  logic [31:0]     instr_r;
  logic            free_s;
  logic            stall_s;
  logic            accept_s;
  logic [4:0]      rs_s;
  logic [4:0]      rt_s;

  assign rs_s = in_instr[25:21];
  assign rt_s = in_instr[20:16];

  decode_logic u_decode_logic (
    .op    (in_instr[31:26]),
    .rt    (rt_s),
    .rd    (in_instr[15:11]),
    .funct (in_instr[5:0]),
    .ctrl  (dec_s)
  );

  // Load-use hazard: the load sitting in the output register feeds a source of the incoming instruction.
  always_comb begin
    stall_s = 1'b0;
    if (HAZARD_EN != 0) begin
      if (valid_r && ctrl_r.memtoreg && ctrl_r.regwrite && (ctrl_r.destreg != 5'd0)) begin
        stall_s = (ctrl_r.destreg == rs_s) ||
                  (reads_rt(in_instr[31:26]) && (ctrl_r.destreg == rt_s));
      end else begin
        stall_s = 1'b0;
      end
    end else begin
      stall_s = 1'b0;
    end
  end

  assign free_s   = !valid_r || ex_ready;
  assign in_ready = free_s && !stall_s && !flush;
  assign accept_s = in_valid && in_ready;

  // Pipeline register: flush wins, then load or bubble when free, otherwise hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_r <= 1'b0;
      ctrl_r  <= ctrl_zero();
      pc_r    <= {PC_W{1'b0}};
      instr_r <= 32'd0;
    end else if (flush) begin
      valid_r <= 1'b0;
      ctrl_r  <= ctrl_zero();
    end else if (free_s) begin
      if (accept_s) begin
        valid_r <= 1'b1;
        ctrl_r  <= dec_s;
        pc_r    <= in_pc;
        instr_r <= in_instr;
      end else begin
        valid_r <= 1'b0;
        ctrl_r  <= ctrl_zero();
      end
    end else begin
      valid_r <= valid_r;
    end
  end

  assign ex_valid      = valid_r;
  assign ex_pc         = pc_r;
  assign ex_instr      = instr_r;
  assign ex_regwrite   = ctrl_r.regwrite;
  assign ex_memwrite   = ctrl_r.memwrite;
  assign ex_memtoreg   = ctrl_r.memtoreg;
  assign ex_alusrcbimm = ctrl_r.alusrcbimm;
  assign ex_dojump     = ctrl_r.dojump;
  assign ex_beq        = ctrl_r.beq;
  assign ex_bltz       = ctrl_r.bltz;
  assign ex_illegal    = ctrl_r.illegal;
  assign ex_destreg    = ctrl_r.destreg;
  assign ex_alucontrol = ctrl_r.alucontrol;

endmodule

// File: tb/tb_decode_stage.sv
// Directed-vector bench for decode_stage; a second instance with HAZARD_EN=0 shares the stimulus.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        flush;
  logic        ex_ready;

  logic        in_ready, ex_valid;
  logic [31:0] ex_pc, ex_instr;
  logic        ex_regwrite, ex_memwrite, ex_memtoreg, ex_alusrcbimm;
  logic        ex_dojump, ex_beq, ex_bltz, ex_illegal;
  logic [4:0]  ex_destreg;
  logic [2:0]  ex_alucontrol;

  logic        n_in_ready, n_ex_valid;
  logic [31:0] n_ex_pc, n_ex_instr;
  logic        n_regwrite, n_memwrite, n_memtoreg, n_alusrcbimm;
  logic        n_dojump, n_beq, n_bltz, n_illegal;
  logic [4:0]  n_destreg;
  logic [2:0]  n_alucontrol;

  int vectors = 0;
  int miscompares = 0;

  // {illegal, regwrite, memwrite, memtoreg, alusrcbimm, dojump, beq, bltz, destreg, alucontrol}
  logic [15:0] obs;
  assign obs = {ex_illegal, ex_regwrite, ex_memwrite, ex_memtoreg, ex_alusrcbimm,
                ex_dojump, ex_beq, ex_bltz, ex_destreg, ex_alucontrol};

  always #5 clk = ~clk;

  decode_stage #(.PC_W(32), .HAZARD_EN(1)) u_dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc),
    .in_ready(in_ready), .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid),
    .ex_pc(ex_pc), .ex_instr(ex_instr), .ex_regwrite(ex_regwrite), .ex_memwrite(ex_memwrite),
    .ex_memtoreg(ex_memtoreg), .ex_alusrcbimm(ex_alusrcbimm), .ex_dojump(ex_dojump),
    .ex_beq(ex_beq), .ex_bltz(ex_bltz), .ex_illegal(ex_illegal), .ex_destreg(ex_destreg),
    .ex_alucontrol(ex_alucontrol)
  );

  decode_stage #(.PC_W(32), .HAZARD_EN(0)) u_nohz (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc),
    .in_ready(n_in_ready), .flush(flush), .ex_ready(ex_ready), .ex_valid(n_ex_valid),
    .ex_pc(n_ex_pc), .ex_instr(n_ex_instr), .ex_regwrite(n_regwrite), .ex_memwrite(n_memwrite),
    .ex_memtoreg(n_memtoreg), .ex_alusrcbimm(n_alusrcbimm), .ex_dojump(n_dojump),
    .ex_beq(n_beq), .ex_bltz(n_bltz), .ex_illegal(n_illegal), .ex_destreg(n_destreg),
    .ex_alucontrol(n_alucontrol)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b0; in_instr = 32'd0; in_pc = 32'd0;
    flush = 1'b0; ex_ready = 1'b1;
    #12;
    vectors++;
    if ({ex_valid, obs} !== 17'd0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %h want 0", {ex_valid, obs});
    end
    vectors++;
    if ({ex_pc, ex_instr} !== 64'd0) begin
      miscompares++;
      $display("FAIL reset_data: got pc %h instr %h want 0", ex_pc, ex_instr);
    end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_addu();
    in_valid = 1'b1; in_instr = 32'h00851821; in_pc = 32'h100; ex_ready = 1'b1;
    tick();
    vectors++;
    if ({ex_valid, ex_pc, ex_instr, obs} !== {1'b1, 32'h100, 32'h00851821, 8'b0100_0000, 5'd3, 3'b010}) begin
      miscompares++;
      $display("FAIL addu: got v=%b pc=%h ctrl=%h want v=1 pc=100 ctrl=%h",
               ex_valid, ex_pc, obs, {8'b0100_0000, 5'd3, 3'b010});
    end
    in_valid = 1'b0;
  endtask

  task automatic test_load_use();
    in_valid = 1'b1; in_instr = 32'h8C820000; in_pc = 32'h104; ex_ready = 1'b1;
    tick();
    vectors++;
    if ({ex_valid, obs} !== {1'b1, 8'b0101_1000, 5'd2, 3'b010}) begin
      miscompares++;
      $display("FAIL lw: got v=%b ctrl=%h want v=1 ctrl=%h", ex_valid, obs, {8'b0101_1000, 5'd2, 3'b010});
    end
    in_instr = 32'h00431021; in_pc = 32'h108;
    #1;
    vectors++;
    if ({in_ready, n_in_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL stall_ready: got hz=%b nohz=%b want hz=0 nohz=1", in_ready, n_in_ready);
    end
    tick();
    vectors++;
    if (ex_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_bubble: got ex_valid %b want 0", ex_valid);
    end
    vectors++;
    if ({n_ex_valid, n_ex_instr, n_destreg} !== {1'b1, 32'h00431021, 5'd2}) begin
      miscompares++;
      $display("FAIL nohz_issue: got v=%b instr=%h rd=%0d want v=1 instr=00431021 rd=2",
               n_ex_valid, n_ex_instr, n_destreg);
    end
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_release: got in_ready %b want 1", in_ready);
    end
    tick();
    vectors++;
    if ({ex_valid, ex_pc, ex_instr, ex_destreg} !== {1'b1, 32'h108, 32'h00431021, 5'd2}) begin
      miscompares++;
      $display("FAIL stall_issue: got v=%b pc=%h instr=%h rd=%0d want v=1 pc=108 instr=00431021 rd=2",
               ex_valid, ex_pc, ex_instr, ex_destreg);
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    in_valid = 1'b1; in_instr = 32'h34071234; in_pc = 32'h200; ex_ready = 1'b1;
    tick();
    ex_ready = 1'b0; in_instr = 32'hAC450004; in_pc = 32'h204;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++;
      if (in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_ready[%0d]: got %b want 0", i, in_ready);
      end
      tick();
      vectors++;
      if ({ex_valid, ex_pc, ex_instr, obs} !== {1'b1, 32'h200, 32'h34071234, 8'b0100_1000, 5'd7, 3'b001}) begin
        miscompares++;
        $display("FAIL bp_hold[%0d]: got v=%b pc=%h instr=%h ctrl=%h want ori at 200",
                 i, ex_valid, ex_pc, ex_instr, obs);
      end
    end
    ex_ready = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_resume_ready: got %b want 1", in_ready);
    end
    tick();
    vectors++;
    if ({ex_valid, ex_pc, obs} !== {1'b1, 32'h204, 8'b0010_1000, 5'd0, 3'b010}) begin
      miscompares++;
      $display("FAIL bp_sw: got v=%b pc=%h ctrl=%h want v=1 pc=204 ctrl=%h",
               ex_valid, ex_pc, obs, {8'b0010_1000, 5'd0, 3'b010});
    end
    in_valid = 1'b0;
    tick();
    vectors++;
    if (ex_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_no_dup: got ex_valid %b want 0", ex_valid);
    end
  endtask

  task automatic test_flush();
    in_valid = 1'b1; in_instr = 32'h00851821; in_pc = 32'h300; ex_ready = 1'b1;
    tick();
    in_instr = 32'h10220004; in_pc = 32'h304; flush = 1'b1; ex_ready = 1'b0;
    #1;
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_ready: got %b want 0", in_ready);
    end
    tick();
    vectors++;
    if (ex_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_kill: got ex_valid %b want 0", ex_valid);
    end
    flush = 1'b0; ex_ready = 1'b1;
    tick();
    vectors++;
    if ({ex_valid, ex_pc, obs} !== {1'b1, 32'h304, 8'b0000_0010, 5'd0, 3'b110}) begin
      miscompares++;
      $display("FAIL beq: got v=%b pc=%h ctrl=%h want v=1 pc=304 ctrl=%h",
               ex_valid, ex_pc, obs, {8'b0000_0010, 5'd0, 3'b110});
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_decode_table();
    logic [31:0] instrs [11];
    logic [15:0] exps [11];
    instrs[0]  = 32'hFC000000; exps[0]  = {8'b1000_0000, 5'd0, 3'b011};
    instrs[1]  = 32'h00851800; exps[1]  = {8'b1000_0000, 5'd0, 3'b011};
    instrs[2]  = 32'h04610000; exps[2]  = {8'b1000_0000, 5'd0, 3'b011};
    instrs[3]  = 32'h04600008; exps[3]  = {8'b0000_0001, 5'd0, 3'b101};
    instrs[4]  = 32'h3C081234; exps[4]  = {8'b0100_1000, 5'd8, 3'b100};
    instrs[5]  = 32'h08000010; exps[5]  = {8'b0000_0100, 5'd0, 3'b011};
    instrs[6]  = 32'h2529FFFF; exps[6]  = {8'b0100_1000, 5'd9, 3'b010};
    instrs[7]  = 32'h00A62023; exps[7]  = {8'b0100_0000, 5'd4, 3'b110};
    instrs[8]  = 32'h00A62024; exps[8]  = {8'b0100_0000, 5'd4, 3'b000};
    instrs[9]  = 32'h00A62025; exps[9]  = {8'b0100_0000, 5'd4, 3'b001};
    instrs[10] = 32'h00A6202B; exps[10] = {8'b0100_0000, 5'd4, 3'b111};
    ex_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      in_valid = 1'b1; in_instr = instrs[i]; in_pc = 32'h400 + 32'(i * 4);
      tick();
      vectors++;
      if ({ex_valid, obs} !== {1'b1, exps[i]}) begin
        miscompares++;
        $display("FAIL decode[%0d] %h: got v=%b ctrl=%h want v=1 ctrl=%h",
                 i, instrs[i], ex_valid, obs, exps[i]);
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    in_valid = 1'b1; in_instr = 32'h00851821; in_pc = 32'h500; ex_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    #3;
    reset_n = 1'b0;
    #1;
    vectors++;
    if ({ex_valid, obs, ex_pc, ex_instr} !== 81'd0) begin
      miscompares++;
      $display("FAIL async_reset: got v=%b ctrl=%h pc=%h instr=%h want all 0",
               ex_valid, obs, ex_pc, ex_instr);
    end
    @(negedge clk);
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_addu();
    test_load_use();
    test_backpressure();
    test_flush();
    test_decode_table();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, parametrised instruction-decode stage for the pipelined MIPS-subset core. It sits between instruction fetch and execute: it accepts one instruction per cycle over a valid/ready handshake, decodes it into the execute-stage control bundle, and holds the result in a pipeline register. It adds load-use hazard stalling, flush on taken branch/jump, and explicit illegal-instruction flagging. Branch resolution moves to execute, so decode no longer consumes `zero`.

## Interface

- `PC_W`, default 32: width of the program counter carried alongside the instruction.
- `HAZARD_EN`, default 1: 1 = load-use stall logic present; 0 = never stall, for software-scheduled code.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: fetch presents an instruction.
- `in_instr` in 32: instruction word.
- `in_pc` in PC_W: address of `in_instr`.
- `in_ready` out 1: decode accepts this cycle.
- `flush` in 1: execute resolved a taken branch/jump; kill in-flight work.
- `ex_ready` in 1: execute consumes the output register this cycle.
- `ex_valid` out 1: output register holds a live instruction.
- `ex_pc` out PC_W: PC of the decoded instruction.
- `ex_instr` out 32: raw instruction, passed through for immediate/jump-target extraction.
- `ex_regwrite`, `ex_memwrite`, `ex_memtoreg`, `ex_alusrcbimm`, `ex_dojump`, `ex_beq`, `ex_bltz`, `ex_illegal` out 1 each: control flags.
- `ex_destreg` out 5: target register.
- `ex_alucontrol` out 3: ALU operation.

## Operation

- ALU codes: and 000, or 001, add 010, undefined 011, lui (B<<16) 100, lt-zero (signed A<0) 101, sub 110, sltu 111.
- R-type (op 000000): addu 100001 → 010, subu 100011 → 110, and 100100 → 000, or 100101 → 001, sltu 101011 → 111. Set regwrite; destreg = rd. Any other funct → ex_illegal.
- lw 100011: add, alusrcbimm, memtoreg, regwrite, destreg = rt. sw 101011: add, alusrcbimm, memwrite, no regwrite.
- beq 000100: sub, ex_beq. bltz 000001 with rt = 0: code 101, ex_bltz; nonzero rt → illegal.
- addiu 001001: add, imm. ori 001101: or, imm. lui 001111: code 100, imm. All three regwrite, destreg = rt.
- j 000010: ex_dojump, alucontrol 011.
- Illegal: ex_illegal=1; regwrite, memwrite, dojump, beq and bltz forced 0; alucontrol 011; destreg 0. Never emit X.
- destreg is 0 whenever regwrite is 0.
- Load-use hazard: ex_valid and ex_memtoreg and ex_regwrite, ex_destreg != 0, and equal to the incoming rs, or to rt for R-type/beq/sw. Then stall=1.

## Timing

- Reset: ex_valid and every control output 0, ex_destreg 0, ex_pc 0, ex_instr 0.
- Latency: one cycle from accept to ex_valid.
- Output register is free when `!ex_valid || ex_ready`. in_ready = free && !stall && !flush.
- Accept when in_valid && in_ready. The output register loads the decode result.
- Free but not accepting: load a bubble (ex_valid=0).
- Not free: hold all outputs unchanged, even if in_valid drops.
- flush: highest priority. Next cycle ex_valid=0 regardless of ex_ready; the incoming instruction is not accepted.
- Stall: one bubble per hazard. The following cycle the load has left, so the same instruction is accepted.
- Reset asserted mid-operation: clears immediately, asynchronously; the in-flight instruction is lost.

## Structure

- `decode_pkg`:
  - opcode and funct localparams;
  - ALU code localparams;
  - packed struct `ctrl_t` for the control bundle.
- Sub-module `decode_logic`: purely combinational instr → ctrl_t, including illegal detection.
- `decode_stage`: handshake, hazard compare, flush and the pipeline register.

## Test plan

- Reset, then addu 0x00851821: one cycle later ex_valid=1, regwrite=1, destreg=3, alucontrol=010.
- lw 0x8C820000 (rt=2), followed by addu using rs=2, with ex_ready=1: in_ready=0 for one cycle, one bubble, addu issued next cycle. Same with HAZARD_EN=0: no bubble.
- ex_ready=0 for 3 cycles with a valid output: outputs stable, in_ready=0, then resume with no loss or duplication.
- flush together with in_valid for beq 0x10220004: next cycle ex_valid=0, and beq is not accepted.
- Opcode 0x3F and R-type funct 0x00: ex_illegal=1, all write enables 0, alucontrol=011. bltz with rt=1 → illegal.
- reset_n pulsed low mid-stream, between clock edges: outputs clear without waiting for a clock edge.
